// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, control bus bit
// positions, FSM state encoding, opcode groups and ALU operation codes.
package ctrl_pkg;

  localparam int OP_R     = 0;
  localparam int OP_J     = 2;
  localparam int OP_JAL   = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_ADDI  = 8;
  localparam int OP_ADDIU = 9;
  localparam int OP_SLTI  = 10;
  localparam int OP_SLTIU = 11;
  localparam int OP_ANDI  = 12;
  localparam int OP_ORI   = 13;
  localparam int OP_LUI   = 15;
  localparam int OP_LW    = 35;
  localparam int OP_SW    = 43;

  localparam int B_REG_DEST   = 0;
  localparam int B_JUMP       = 1;
  localparam int B_BEQ        = 2;
  localparam int B_BNE        = 3;
  localparam int B_MEM_WRITE  = 4;
  localparam int B_MEM_READ   = 5;
  localparam int B_ALU_OP0    = 6;
  localparam int B_ALU_OP1    = 7;
  localparam int B_MEM_TO_REG = 8;
  localparam int B_WRITE_REG  = 9;
  localparam int B_ALU_SRC    = 10;
  localparam int B_LUI        = 11;

  // Values for ctrl[7:6]; the datapath reads alu_op as the pair "op0 op1",
  // so R-type "10" sets bit 6 and branch "01" sets bit 7.
  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_R  = 2'b01;
  localparam logic [1:0] ALUOP_BR = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    G_R, G_LW, G_SW, G_BEQ, G_BNE, G_ADD, G_SLT, G_AND, G_OR,
    G_LUI, G_J, G_JAL, G_ILL
  } grp_t;

  function automatic grp_t op_group(input int op);
    case (op)
      OP_R:               return G_R;
      OP_LW:              return G_LW;
      OP_SW:              return G_SW;
      OP_BEQ:             return G_BEQ;
      OP_BNE:             return G_BNE;
      OP_ADDI, OP_ADDIU:  return G_ADD;
      OP_SLTI, OP_SLTIU:  return G_SLT;
      OP_ANDI:            return G_AND;
      OP_ORI:             return G_OR;
      OP_LUI:             return G_LUI;
      OP_J:               return G_J;
      OP_JAL:             return G_JAL;
      default:            return G_ILL;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational map of (latched opcode, state) to the control bus, I-type ALU
// operation and link flag; also exposes the opcode group to the FSM.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] op_q,
  input  state_t              st,
  output logic [11:0]         ctrl,
  output logic [3:0]          i_op,
  output logic                link,
  output grp_t                grp
);

  logic [11:0] exe;
  logic [3:0]  iop;

  always_comb begin
    grp  = op_group(int'(op_q));
    exe  = '0;
    iop  = '0;
    ctrl = '0;
    i_op = '0;
    link = 1'b0;

    case (grp)
      G_R: begin
        exe[B_REG_DEST] = 1'b1;
        exe[B_ALU_OP1:B_ALU_OP0] = ALUOP_R;
      end
      G_LW, G_SW: begin
        exe[B_ALU_SRC] = 1'b1;
        exe[B_ALU_OP1:B_ALU_OP0] = ALUOP_LS;
      end
      G_BEQ: begin
        exe[B_BEQ] = 1'b1;
        exe[B_ALU_OP1:B_ALU_OP0] = ALUOP_BR;
      end
      G_BNE: begin
        exe[B_BNE] = 1'b1;
        exe[B_ALU_OP1:B_ALU_OP0] = ALUOP_BR;
      end
      G_ADD, G_SLT, G_AND, G_OR: begin
        exe[B_ALU_SRC] = 1'b1;
        exe[B_ALU_OP1:B_ALU_OP0] = ALUOP_I;
        iop = (grp == G_ADD) ? ALU_ADD :
              (grp == G_SLT) ? ALU_SLT :
              (grp == G_AND) ? ALU_AND : ALU_OR;
      end
      G_LUI: begin
        exe[B_ALU_SRC] = 1'b1;
        exe[B_LUI]     = 1'b1;
      end
      G_J, G_JAL: exe[B_JUMP] = 1'b1;
      default: exe = '0;
    endcase

    case (st)
      S_FETCH: ctrl[B_MEM_READ] = 1'b1;
      S_EXEC: begin
        ctrl = exe;
        i_op = iop;
      end
      S_MEM: begin
        if (grp == G_LW) begin
          ctrl[B_MEM_READ] = 1'b1;
          ctrl[B_ALU_SRC]  = 1'b1;
        end else if (grp == G_SW) begin
          ctrl[B_MEM_WRITE] = 1'b1;
          ctrl[B_ALU_SRC]   = 1'b1;
        end
      end
      S_WB: begin
        ctrl = exe;
        ctrl[B_WRITE_REG] = 1'b1;
        i_op = iop;
        if (grp == G_LW) ctrl[B_MEM_TO_REG] = 1'b1;
        if (grp == G_JAL) begin
          ctrl[B_JUMP] = 1'b0;
          link = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory ack wait,
// stall freeze, bounded memory timeout and illegal-opcode detection.
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ack,
  input  logic                stall,
  output logic [11:0]         ctrl,
  output logic [3:0]          i_op,
  output logic                link,
  output logic                ir_write,
  output logic                pc_write,
  output logic                illegal,
  output logic                bus_err,
  output logic                retire,
  output logic [2:0]          state
);

  state_t              cur;
  logic [OPCODE_W-1:0] op_q;
  logic [TO_W-1:0]     cnt;
  grp_t                grp;
  logic                active;
  logic                waiting;
  logic                tmo;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .op_q (op_q),
    .st   (cur),
    .ctrl (ctrl),
    .i_op (i_op),
    .link (link),
    .grp  (grp)
  );

  assign state   = cur;
  assign active  = rst && !stall;
  assign waiting = (cur == S_FETCH || cur == S_MEM) && !mem_ack;
  // An ack in the same cycle wins over the timeout because waiting excludes it.
  assign tmo     = waiting && (MEM_TIMEOUT != 0) && (cnt == TO_W'(MEM_TIMEOUT));

  always_comb begin
    ir_write = active && cur == S_FETCH && mem_ack;
    pc_write = ir_write || (active && cur == S_EXEC && (grp == G_J || grp == G_JAL));
    illegal  = active && cur == S_DECODE && op_group(int'(opcode)) == G_ILL;
    bus_err  = active && tmo;
    retire   = illegal ||
               (active && ((cur == S_EXEC && (grp == G_BEQ || grp == G_BNE || grp == G_J)) ||
                           (cur == S_MEM && grp == G_SW && mem_ack) ||
                           cur == S_WB));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur  <= S_FETCH;
      op_q <= '0;
      cnt  <= '0;
    end else if (!stall) begin
      cnt <= '0;
      if (waiting && !tmo && MEM_TIMEOUT != 0) cnt <= cnt + 1'b1;
      case (cur)
        S_FETCH: begin
          if (mem_ack) cur <= S_DECODE;
          else if (tmo) cur <= S_FETCH;
        end
        S_DECODE: begin
          if (op_group(int'(opcode)) == G_ILL) begin
            cur <= S_FETCH;
          end else begin
            cur  <= S_EXEC;
            op_q <= opcode;
          end
        end
        S_EXEC: begin
          case (grp)
            G_LW, G_SW:         cur <= S_MEM;
            G_BEQ, G_BNE, G_J:  cur <= S_FETCH;
            G_ILL:              cur <= S_FETCH;
            default:            cur <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ack) cur <= (grp == G_LW) ? S_WB : S_FETCH;
          else if (tmo) cur <= S_FETCH;
        end
        default: cur <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench: each driven cycle pushes its hand-computed expected outputs;
// a separate monitor pops and compares them on the falling edge.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ack;
  logic        stall;
  logic [11:0] ctrl;
  logic [3:0]  i_op;
  logic        link, ir_write, pc_write, illegal, bus_err, retire;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  logic [24:0] exp_q[$];
  string       name_q[$];

  localparam logic [5:0] P_L  = 6'b100000;
  localparam logic [5:0] P_IR = 6'b010000;
  localparam logic [5:0] P_PC = 6'b001000;
  localparam logic [5:0] P_IL = 6'b000100;
  localparam logic [5:0] P_BE = 6'b000010;
  localparam logic [5:0] P_RT = 6'b000001;
  localparam logic [5:0] P_FD = 6'b011000;

  mc_control_unit #(.OPCODE_W(6), .MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .mem_ack  (mem_ack),
    .stall    (stall),
    .ctrl     (ctrl),
    .i_op     (i_op),
    .link     (link),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .retire   (retire),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [5:0] op, input logic ack,
                      input logic stl, input logic [2:0] st, input logic [11:0] c,
                      input logic [3:0] io, input logic [5:0] p, input string nm);
    rst     = r;
    opcode  = op;
    mem_ack = ack;
    stall   = stl;
    exp_q.push_back({st, c, io, p});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // FETCH with immediate ack followed by DECODE of a legal opcode.
  task automatic fetch_dec(input logic [5:0] op, input string nm);
    step(1, op, 1, 0, 3'd0, 12'h020, 4'd0, P_FD, {nm, "_fetch"});
    step(1, op, 0, 0, 3'd1, 12'h000, 4'd0, 6'b0, {nm, "_decode"});
  endtask

  initial begin : monitor
    logic [24:0] e;
    logic [24:0] act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {state, ctrl, i_op, link, ir_write, pc_write, illegal, bus_err, retire};
        checks++;
        if (act !== e)
          begin
            failures++;
            $display("FAIL %s: got st=%0d ctrl=%h iop=%0d lk/ir/pc/il/be/rt=%b, want st=%0d ctrl=%h iop=%0d lk/ir/pc/il/be/rt=%b",
                     nm, act[24:22], act[21:10], act[9:6], act[5:0],
                     e[24:22], e[21:10], e[9:6], e[5:0]);
          end
      end
    end
  end

  initial begin
    rst = 1'b0; opcode = 6'd8; mem_ack = 1'b1; stall = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(0, 8, 1, 0, 3'd0, 12'h020, 4'd0, 6'b0, "reset");

    // ADDI
    fetch_dec(8, "addi");
    step(1, 8, 0, 0, 3'd2, 12'h4C0, 4'd2, 6'b0, "addi_exec");
    step(1, 8, 0, 0, 3'd4, 12'h6C0, 4'd2, P_RT, "addi_wb");

    // LW with ack on third MEM cycle
    fetch_dec(35, "lw");
    step(1, 35, 0, 0, 3'd2, 12'h400, 4'd0, 6'b0, "lw_exec");
    step(1, 35, 0, 0, 3'd3, 12'h420, 4'd0, 6'b0, "lw_mem1");
    step(1, 35, 0, 0, 3'd3, 12'h420, 4'd0, 6'b0, "lw_mem2");
    step(1, 35, 1, 0, 3'd3, 12'h420, 4'd0, 6'b0, "lw_mem3");
    step(1, 35, 0, 0, 3'd4, 12'h700, 4'd0, P_RT, "lw_wb");

    // JAL
    fetch_dec(3, "jal");
    step(1, 3, 0, 0, 3'd2, 12'h002, 4'd0, P_PC, "jal_exec");
    step(1, 3, 0, 0, 3'd4, 12'h200, 4'd0, P_L | P_RT, "jal_wb");

    // Illegal opcode
    step(1, 63, 1, 0, 3'd0, 12'h020, 4'd0, P_FD, "ill_fetch");
    step(1, 63, 0, 0, 3'd1, 12'h000, 4'd0, P_IL | P_RT, "ill_decode");

    // R-type with one FETCH wait cycle
    step(1, 0, 0, 0, 3'd0, 12'h020, 4'd0, 6'b0, "r_fetch_wait");
    fetch_dec(0, "r");
    step(1, 0, 0, 0, 3'd2, 12'h041, 4'd0, 6'b0, "r_exec");
    step(1, 0, 0, 0, 3'd4, 12'h241, 4'd0, P_RT, "r_wb");

    // BEQ stalled in EXEC for two cycles
    fetch_dec(4, "beq");
    step(1, 4, 1, 1, 3'd2, 12'h084, 4'd0, 6'b0, "beq_stall1");
    step(1, 4, 1, 1, 3'd2, 12'h084, 4'd0, 6'b0, "beq_stall2");
    step(1, 4, 0, 0, 3'd2, 12'h084, 4'd0, P_RT, "beq_release");

    // BNE with a stalled ack in FETCH (ack ignored)
    step(1, 5, 1, 1, 3'd0, 12'h020, 4'd0, 6'b0, "bne_fetch_stall");
    fetch_dec(5, "bne");
    step(1, 5, 0, 0, 3'd2, 12'h088, 4'd0, P_RT, "bne_exec");

    // ORI, SLTI, LUI, J
    fetch_dec(13, "ori");
    step(1, 13, 0, 0, 3'd2, 12'h4C0, 4'd1, 6'b0, "ori_exec");
    step(1, 13, 0, 0, 3'd4, 12'h6C0, 4'd1, P_RT, "ori_wb");
    fetch_dec(10, "slti");
    step(1, 10, 0, 0, 3'd2, 12'h4C0, 4'd7, 6'b0, "slti_exec");
    step(1, 10, 0, 0, 3'd4, 12'h6C0, 4'd7, P_RT, "slti_wb");
    fetch_dec(15, "lui");
    step(1, 15, 0, 0, 3'd2, 12'hC00, 4'd0, 6'b0, "lui_exec");
    step(1, 15, 0, 0, 3'd4, 12'hE00, 4'd0, P_RT, "lui_wb");
    fetch_dec(2, "j");
    step(1, 2, 0, 0, 3'd2, 12'h002, 4'd0, P_PC | P_RT, "j_exec");

    // SW timeout in MEM: bus_err on the 16th wait cycle, no retire
    fetch_dec(43, "sw_to");
    step(1, 43, 0, 0, 3'd2, 12'h400, 4'd0, 6'b0, "sw_to_exec");
    for (int i = 0; i < 15; i++) step(1, 43, 0, 0, 3'd3, 12'h410, 4'd0, 6'b0, "sw_to_wait");
    step(1, 43, 0, 0, 3'd3, 12'h410, 4'd0, P_BE, "sw_to_buserr");

    // SW with ack exactly on the 16th MEM cycle: ack wins
    fetch_dec(43, "sw_late");
    step(1, 43, 0, 0, 3'd2, 12'h400, 4'd0, 6'b0, "sw_late_exec");
    for (int i = 0; i < 15; i++) step(1, 43, 0, 0, 3'd3, 12'h410, 4'd0, 6'b0, "sw_late_wait");
    step(1, 43, 1, 0, 3'd3, 12'h410, 4'd0, P_RT, "sw_late_ack");

    // FETCH timeout: retry without pc_write
    for (int i = 0; i < 15; i++) step(1, 8, 0, 0, 3'd0, 12'h020, 4'd0, 6'b0, "fetch_to_wait");
    step(1, 8, 0, 0, 3'd0, 12'h020, 4'd0, P_BE, "fetch_to_buserr");

    // Reset mid-instruction aborts with no retire
    fetch_dec(8, "abort");
    step(0, 8, 0, 0, 3'd2, 12'h4C0, 4'd2, 6'b0, "abort_rst_exec");
    step(1, 8, 0, 0, 3'd0, 12'h020, 4'd0, 6'b0, "abort_after");

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS control unit: sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the 12-bit datapath control bus and the 4-bit I-type ALU operation per state. It replaces single-cycle opcode decoding in the core and sits between the instruction register and the shared datapath. It adds a memory ready handshake, a pipeline stall input, a configurable memory timeout, and illegal-opcode detection.

## Interface
- OPCODE_W, default 6: opcode field width.
- MEM_TIMEOUT, default 15: maximum wait cycles for `mem_ack` in FETCH or MEM; 0 disables the timeout.
- TO_W, default 4: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- opcode  in  OPCODE_W  instruction[31:26]; sampled in DECODE.
- mem_ack  in  1  memory access complete (FETCH/MEM).
- stall  in  1  freeze the FSM.
- ctrl  out  12  control bus; bit 0 reg_dest, 1 jump, 2 beq, 3 bne, 4 mem_write, 5 mem_read, 6 alu_op0, 7 alu_op1, 8 mem_to_reg, 9 write_reg, 10 alu_src, 11 lui.
- i_op  out  4  ALU operation for I-type instructions.
- link  out  1  JAL write to $31 with PC+4.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- bus_err  out  1  one-cycle pulse on memory timeout.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
- **Latched opcode.** `op_q` latches `opcode` on the DECODE→EXEC transition. EXEC, MEM and WB outputs decode from `op_q`.
- **Opcode groups.**
  - R: 0.
  - LW: 35. SW: 43.
  - BEQ: 4. BNE: 5.
  - ADDI/ADDIU: 8/9. SLTI/SLTIU: 10/11. ANDI: 12. ORI: 13.
  - LUI: 15.
  - J: 2. JAL: 3.
  - Any other value is illegal.
- **FETCH.** mem_read=1. Wait for `mem_ack`; on ack, ir_write=1 and pc_write=1 (PC+4), then go to DECODE.
- **DECODE.** ctrl=0. A legal opcode goes to EXEC. An illegal opcode pulses `illegal` and `retire`, then returns to FETCH.
- **EXEC.** The memory and writeback bits (4, 5, 8, 9) are 0.
  - R: reg_dest=1, alu_op=10; go to WB.
  - LW/SW: alu_src=1, alu_op=00; go to MEM.
  - BEQ/BNE: beq or bne=1, alu_op=01; retire, go to FETCH.
  - I-ALU: alu_src=1, alu_op=11; i_op = ADD/SLT/AND/OR; go to WB.
  - LUI: alu_src=1, lui=1; go to WB.
  - J: jump=1, pc_write=1; retire, go to FETCH.
  - JAL: jump=1, pc_write=1; go to WB.
- **MEM.** LW: mem_read=1, alu_src=1. SW: mem_write=1, alu_src=1. Wait for `mem_ack`. On ack, LW goes to WB; SW retires and goes to FETCH.
- **WB.** write_reg=1 plus the EXEC bits for the group, except:
  - LW: mem_to_reg=1.
  - JAL: link=1, jump=0.
  - Retire, go to FETCH.
- **i_op.** Non-zero only for the I-ALU group in EXEC and WB; otherwise 0.
- **Stall.** `stall` high holds state, `op_q` and the timeout counter. While stalled, ir_write, pc_write, retire, illegal and bus_err are 0, and ctrl/i_op hold their current values. `mem_ack` is ignored while stalled.
- **Timeout.** The counter clears on entry to FETCH or MEM and counts each non-stalled wait cycle without ack. When the counter equals MEM_TIMEOUT and no ack arrives that cycle, `bus_err` pulses and the FSM goes to FETCH. From FETCH this is a retry with no pc_write. From MEM the instruction is abandoned with no retire. An ack in the same cycle takes priority over the timeout.

## Timing
- **ctrl, i_op, link.** Moore outputs, combinational from `state` and `op_q`.
- **ir_write, pc_write, retire, illegal, bus_err.** Combinational from state and inputs.
- **Reset.** While `rst` is low at a clk edge: state=FETCH, op_q=0, counter=0. Consequently ctrl=12'h020 and i_op=0. Pulse outputs are forced 0 while `rst` is low. Reset mid-instruction aborts it with no retire.
- **Latency with single-cycle ack:**
  - R, I-ALU, LUI, JAL: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Each memory wait cycle adds 1.
- **Back-to-back.** The cycle after retire is FETCH.

## Structure
- **Package `ctrl_pkg`:** opcode constants, ctrl bit indices, state encoding, and ALU codes (ALU_AND=4'd0, ALU_OR=4'd1, ALU_ADD=4'd2, ALU_SLT=4'd7).
- **Sub-module `ctrl_decode`:** combinational map of (op_q, state) to ctrl, i_op and link, plus legal/group flags. The FSM and timeout counter stay in `mc_control_unit`.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with mem_ack=1 → state=0, ctrl=12'h020, ir_write=0, retire=0.
- **ADDI:** opcode=8, ack on the first FETCH cycle → states 0,1,2,4,0. EXEC ctrl=12'h4C0 with i_op=2. WB ctrl=12'h6C0. retire on cycle 4.
- **LW with latency:** LW with a 3-cycle ack delay in MEM → MEM holds ctrl=12'h420 for 3 cycles. WB ctrl=12'h700. Total 7 cycles.
- **JAL and illegal:** JAL → EXEC ctrl=12'h002 with pc_write=1; WB link=1 with ctrl=12'h200. Opcode=6'd63 → illegal pulses in DECODE, next state FETCH.
- **Stall:** stall=1 for 2 cycles in EXEC of BEQ → state=2 and ctrl=12'h084 held, pc_write=0, no retire. Retire follows release.
- **Timeout:** MEM_TIMEOUT=15, SW with no ack → bus_err on MEM cycle 16, then state=0, no retire. An ack arriving on cycle 16 instead gives retire and no bus_err.
